// File: rtl/pll_lock_sequencer.sv
// Bring-up sequencer for the SB_PLL40: holds the PLL in reset, waits for LOCK with a
// timeout and retry budget, demands a stable lock, then releases the design reset.
module pll_lock_sequencer #(
    parameter int  RESET_HOLD   = 16,
    parameter int  LOCK_TIMEOUT = 4096,
    parameter int  LOCK_STABLE  = 1024,
    parameter int  MAX_RETRIES  = 3,
    parameter int  SYNC_STAGES  = 2,
    localparam int RETRY_W      = $clog2(MAX_RETRIES + 1)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               pll_lock,
    input  logic               restart,
    output logic               pll_resetb,
    output logic               sys_reset_n,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [7:0]         loss_cnt,
    output logic [2:0]         dbg_state
);

    localparam int CNT_MAX_A = (RESET_HOLD > LOCK_STABLE) ? RESET_HOLD : LOCK_STABLE;
    localparam int CNT_MAX   = (LOCK_TIMEOUT > CNT_MAX_A) ? LOCK_TIMEOUT : CNT_MAX_A;
    localparam int CNT_W     = $clog2(CNT_MAX);

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [RETRY_W-1:0]   retry_q, retry_d, retry_inc;
    logic [7:0]           loss_q, loss_d;
    logic                 pll_resetb_q, pll_resetb_d;
    logic                 sys_reset_n_q, sys_reset_n_d;
    logic                 ready_q, ready_d;
    logic                 fail_q, fail_d;
    logic                 lock_s;

    // pll_lock comes from the PLL analog domain; only the synchronised copy is trusted.
    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        loss_d    = loss_q;
        retry_inc = retry_q + RETRY_W'(1);

        case (state_q)
            ST_HOLD: begin
                if (cnt_q == CNT_W'(RESET_HOLD - 1)) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RETRY_W'(MAX_RETRIES)) ? ST_FAIL : ST_HOLD;
                end
            end
            ST_STABLE: begin
                if (!lock_s) state_d = ST_WAIT_LOCK;
                else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_HOLD;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase

        // restart overrides every other transition but leaves a same-cycle loss counted.
        if (restart && (state_q != ST_HOLD)) begin
            state_d = ST_HOLD;
            retry_d = '0;
        end

        if ((state_d == ST_RUN) && (state_q != ST_RUN)) retry_d = '0;

        cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);

        pll_resetb_d  = !((state_d == ST_HOLD) || (state_d == ST_FAIL));
        sys_reset_n_d = (state_d == ST_RUN);
        ready_d       = (state_d == ST_RUN);
        fail_d        = (state_d == ST_FAIL);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_HOLD;
            cnt_q         <= '0;
            sync_q        <= '0;
            retry_q       <= '0;
            loss_q        <= '0;
            pll_resetb_q  <= 1'b0;
            sys_reset_n_q <= 1'b0;
            ready_q       <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sync_q        <= {sync_q[SYNC_STAGES-2:0], pll_lock};
            retry_q       <= retry_d;
            loss_q        <= loss_d;
            pll_resetb_q  <= pll_resetb_d;
            sys_reset_n_q <= sys_reset_n_d;
            ready_q       <= ready_d;
            fail_q        <= fail_d;
        end
    end

    assign pll_resetb  = pll_resetb_q;
    assign sys_reset_n = sys_reset_n_q;
    assign ready       = ready_q;
    assign fail        = fail_q;
    assign retry_cnt   = retry_q;
    assign loss_cnt    = loss_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: timing table for lock arrival, then hand-written
// sequences for retry/fail, glitches, lock loss, restart, saturation and async reset.
module tb_pll_lock_sequencer;
    localparam int RESET_HOLD   = 4;
    localparam int LOCK_TIMEOUT = 32;
    localparam int LOCK_STABLE  = 8;
    localparam int MAX_RETRIES  = 2;
    localparam int SYNC_STAGES  = 2;
    localparam int RW           = 2;
    localparam int OW           = 14;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          pll_lock;
    logic          restart;
    logic          pll_resetb;
    logic          sys_reset_n;
    logic          ready;
    logic          fail;
    logic [RW-1:0] retry_cnt;
    logic [7:0]    loss_cnt;
    logic [2:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    logic [OW-1:0] exp_q[$];

    typedef struct {
        int            d;
        int            n;
        logic [OW-1:0] exp;
    } vec_t;

    vec_t tbl[11];

    pll_lock_sequencer #(
        .RESET_HOLD  (RESET_HOLD),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .LOCK_STABLE (LOCK_STABLE),
        .MAX_RETRIES (MAX_RETRIES),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .pll_lock   (pll_lock),
        .restart    (restart),
        .pll_resetb (pll_resetb),
        .sys_reset_n(sys_reset_n),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt),
        .dbg_state  (dbg_state)
    );

    always #5 clock = ~clock;

    // Packed view: {pll_resetb, sys_reset_n, ready, fail, retry_cnt[1:0], loss_cnt[7:0]}
    function automatic logic [OW-1:0] pack_o(int rb, int sr, int rd, int fl, int rc, int lc);
        return {1'(rb), 1'(sr), 1'(rd), 1'(fl), 2'(rc), 8'(lc)};
    endfunction

    function automatic logic [OW-1:0] observed();
        return {pll_resetb, sys_reset_n, ready, fail, retry_cnt, loss_cnt};
    endfunction

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (state %0d)", name, act, exp, dbg_state);
        end
    endtask

    task automatic sb_compare(input string name);
        logic [OW-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no expected entry queued", name);
        end else begin
            e = exp_q.pop_front();
            check_val(name, int'(observed()), int'(e));
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic apply_reset();
        reset_n  = 1'b0;
        pll_lock = 1'b0;
        restart  = 1'b0;
        tick(2);
        reset_n = 1'b1;
    endtask

    task automatic wait_resetb_high(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (pll_resetb === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: pll_resetb=0 after 200 cycles, required 1", name);
        end
    endtask

    task automatic wait_ready_high(input string name, input int limit, output int waited);
        bit seen;
        seen   = 1'b0;
        waited = 0;
        for (int i = 0; i < limit; i++) begin
            if (ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
            waited++;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: ready=0 after %0d cycles, required 1", name, limit);
        end
    endtask

    task automatic count_resetb_low(output int lows);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            if (pll_resetb !== 1'b0) break;
            lows++;
            @(negedge clock);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        int waited;

        // d = negedges after pll_resetb rises before pll_lock is raised,
        // n = negedge (same origin) at which outputs are compared.
        tbl[0]  = '{0,  10, pack_o(1, 0, 0, 0, 0, 0)};
        tbl[1]  = '{0,  11, pack_o(1, 1, 1, 0, 0, 0)};
        tbl[2]  = '{10, 20, pack_o(1, 0, 0, 0, 0, 0)};
        tbl[3]  = '{10, 21, pack_o(1, 1, 1, 0, 0, 0)};
        tbl[4]  = '{29, 39, pack_o(1, 0, 0, 0, 0, 0)};
        tbl[5]  = '{29, 40, pack_o(1, 1, 1, 0, 0, 0)};
        tbl[6]  = '{30, 31, pack_o(1, 0, 0, 0, 0, 0)};
        tbl[7]  = '{30, 32, pack_o(0, 0, 0, 0, 1, 0)};
        tbl[8]  = '{30, 36, pack_o(1, 0, 0, 0, 1, 0)};
        tbl[9]  = '{30, 44, pack_o(1, 0, 0, 0, 1, 0)};
        tbl[10] = '{30, 45, pack_o(1, 1, 1, 0, 0, 0)};

        // Async reset with no clock edge yet
        reset_n  = 1'b1;
        pll_lock = 1'b0;
        restart  = 1'b0;
        #1 reset_n = 1'b0;
        exp_q.push_back(pack_o(0, 0, 0, 0, 0, 0));
        #1 sb_compare("reset_values");

        for (int i = 0; i < 11; i++) begin
            apply_reset();
            wait_resetb_high($sformatf("tbl%0d_resetb", i));
            tick(tbl[i].d);
            pll_lock = 1'b1;
            exp_q.push_back(tbl[i].exp);
            tick(tbl[i].n - tbl[i].d);
            sb_compare($sformatf("tbl%0d_d%0d_n%0d", i, tbl[i].d, tbl[i].n));
        end

        // Bring-up from reset release
        reset_n  = 1'b0;
        pll_lock = 1'b0;
        restart  = 1'b0;
        tick(2);
        reset_n = 1'b1;
        count_resetb_low(lows);
        check_val("bringup_hold_len", lows, RESET_HOLD);
        tick(10);
        pll_lock = 1'b1;
        wait_ready_high("bringup_ready", 40, waited);
        checks++;
        if (waited < 9 || waited > 11) begin
            errors++;
            $display("FAIL bringup_latency: got %0d cycles, required 9..11", waited);
        end
        check_val("bringup_sys_reset_n", sys_reset_n, 1);

        // Lock loss in RUN
        tick(2);
        pll_lock = 1'b0;
        tick(2);
        check_val("loss_ready_before", ready, 1);
        exp_q.push_back(pack_o(0, 0, 0, 0, 0, 1));
        tick(1);
        sb_compare("loss_drop");
        pll_lock = 1'b1;
        count_resetb_low(lows);
        check_val("loss_hold_len", lows, RESET_HOLD);
        wait_ready_high("loss_rerun", 40, waited);
        check_val("loss_cnt_kept", loss_cnt, 1);

        // Restart in RUN
        tick(3);
        restart = 1'b1;
        exp_q.push_back(pack_o(0, 0, 0, 0, 0, 1));
        tick(1);
        restart = 1'b0;
        sb_compare("restart_run");
        wait_ready_high("restart_run_ready", 40, waited);

        // Restart coinciding with a lock loss: the loss still counts
        pll_lock = 1'b0;
        tick(2);
        restart = 1'b1;
        exp_q.push_back(pack_o(0, 0, 0, 0, 0, 2));
        tick(1);
        restart  = 1'b0;
        pll_lock = 1'b1;
        sb_compare("restart_with_loss");
        wait_ready_high("restart_loss_ready", 40, waited);

        // One-cycle glitch in STABLE at cnt=5
        apply_reset();
        wait_resetb_high("glitch_resetb");
        pll_lock = 1'b1;
        tick(6);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        exp_q.push_back(pack_o(1, 0, 0, 0, 0, 0));
        tick(4);
        sb_compare("glitch_no_ready_n11");
        exp_q.push_back(pack_o(1, 0, 0, 0, 0, 0));
        tick(6);
        sb_compare("glitch_no_ready_n17");
        exp_q.push_back(pack_o(1, 1, 1, 0, 0, 0));
        tick(1);
        sb_compare("glitch_ready_n18");

        // Timeout, retry, FAIL, restart from FAIL
        apply_reset();
        wait_resetb_high("timeout_resetb");
        exp_q.push_back(pack_o(1, 0, 0, 0, 0, 0));
        tick(31);
        sb_compare("timeout_before");
        exp_q.push_back(pack_o(0, 0, 0, 0, 1, 0));
        tick(1);
        sb_compare("timeout_retry1");
        count_resetb_low(lows);
        check_val("retry_hold_len", lows, RESET_HOLD);
        exp_q.push_back(pack_o(1, 0, 0, 0, 1, 0));
        tick(31);
        sb_compare("timeout2_before");
        exp_q.push_back(pack_o(0, 0, 0, 1, 2, 0));
        tick(1);
        sb_compare("fail_entry");
        exp_q.push_back(pack_o(0, 0, 0, 1, 2, 0));
        tick(50);
        sb_compare("fail_held");
        restart = 1'b1;
        exp_q.push_back(pack_o(0, 0, 0, 0, 0, 0));
        tick(1);
        restart = 1'b0;
        sb_compare("restart_fail");
        pll_lock = 1'b1;
        wait_ready_high("restart_fail_ready", 60, waited);

        // 256 lock losses: loss_cnt saturates
        apply_reset();
        pll_lock = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            wait_ready_high($sformatf("sat_ready%0d", i), 60, waited);
            pll_lock = 1'b0;
            tick(3);
            pll_lock = 1'b1;
            if (i >= 254) check_val($sformatf("sat_loss%0d", i), loss_cnt, (i > 255) ? 255 : i);
        end

        // Async reset mid-WAIT_LOCK with retry_cnt=1
        wait_ready_high("async_pre_ready", 60, waited);
        pll_lock = 1'b0;
        exp_q.push_back(pack_o(1, 0, 0, 0, 1, 255));
        tick(45);
        sb_compare("async_pre_state");
        #2 reset_n = 1'b0;
        exp_q.push_back(pack_o(0, 0, 0, 0, 0, 0));
        #1 sb_compare("async_reset_values");
        tick(2);
        reset_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
